serial_sub_4bit: RTL and testbench
==================================

# serial_sub_4bit

Bit-serial unsigned subtractor: the inverse operation of the team's 4-bit ripple-carry adder. It computes a − b − bin one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It sits beside the parallel adder as the area-minimal arithmetic unit. A start/busy/done handshake lets a controller or bench issue one operation at a time and compare results against the adder (a = diff + b + bin).

## Interface

- WIDTH, 4, operand and result width in bits (≥ 2).
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  request pulse; accepted only in IDLE.
- a  input  WIDTH  minuend; sampled on the accepting edge only.
- b  input  WIDTH  subtrahend; sampled on the accepting edge only.
- bin  input  1  borrow-in; sampled on the accepting edge only.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; diff/bout valid.
- diff  output  WIDTH  difference, registered.
- bout  output  1  borrow-out, registered.

## Operation

- State machine: IDLE, RUN, DONE.
  - IDLE → RUN on an edge with start=1 (and rst_n=1). On that edge, capture a and b into shift registers, load the borrow flop with bin, and clear the bit counter.
  - RUN, each edge: compute bit i of the difference as d = a_i ^ b_i ^ br, and the next borrow as br' = (~a_i & b_i) | (~(a_i ^ b_i) & br). Shift d into the result register from the MSB end. Increment the counter.
  - RUN → DONE on the edge that processes bit WIDTH−1. On that same edge, load diff with the full result and bout with the final borrow.
  - DONE → IDLE on the next edge unconditionally.
- Arithmetic: {bout, diff} = ({1'b0,a} − {1'b0,b} − bin) mod 2^(WIDTH+1).
  - bout = 1 iff a < b + bin, treating all operands as unsigned.
- diff/bout hold their last value from the DONE-entry edge until the next DONE-entry edge. They are never partially updated during RUN; the shift register is internal.
- start while busy=1 (RUN or DONE) is ignored. It is not queued, and the operand inputs are not resampled.
- Operand inputs may change freely after the accepting edge.
- Counter width: clog2(WIDTH). The counter never wraps within an operation because the FSM exits at count WIDTH−1.

## Timing

- Reset (rst_n=0 at an edge), from any state: state = IDLE, busy = 0, done = 0, diff = 0, bout = 0, counter = 0, borrow flop = 0.
- Reset mid-RUN aborts the operation; no done pulse is produced.
- Reset takes priority over start on the same edge.
- Latency, with the accepting edge as E0:
  - busy = 1 from E0 until E(WIDTH+1).
  - done = 1 for exactly the cycle between E(WIDTH) and E(WIDTH+1).
  - diff/bout change at E(WIDTH).
  - For WIDTH=4: done rises after the 4th edge following acceptance.
- Earliest next acceptance: start=1 sampled at E(WIDTH+1) is ignored, because the FSM is still in DONE at that edge. The first edge that can accept is E(WIDTH+2). Throughput is therefore one operation per WIDTH+2 cycles.
- A start held continuously high launches a new operation every WIDTH+2 cycles.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan

- a=9, b=3, bin=0 → after 4 RUN edges, done pulse for 1 cycle with diff=6, bout=0. busy is high for exactly 5 cycles.
- a=3, b=9, bin=0 → diff=4'hA, bout=1. Then a=0, b=0, bin=1 → diff=4'hF, bout=1. Then a=15, b=15, bin=1 → diff=4'hF, bout=1.
- Exhaustive sweep, all 16×16×2 combinations back-to-back with start pulsed on each idle cycle → every result satisfies diff + b + bin = a + 16·bout, with exactly one done per request.
- Start held high, with a/b toggled every cycle during RUN → result reflects only the operands sampled on the accepting edge. The next operation begins at E6, not E5.
- rst_n driven low at E2 of an operation with a=12, b=5 → done never asserts, diff/bout read 0, busy = 0. A fresh start afterwards returns diff=7, bout=0.
- Reset asserted on the same edge as start → FSM stays IDLE and busy remains 0.

Source files
------------

// File: rtl/serial_sub_4bit_if.sv
// Operation handshake and operand/result bus for the bit-serial subtractor.
// The controller side uses master; the subtractor uses slave.
interface serial_sub_4bit_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_sub_4bit.sv
// Bit-serial unsigned subtractor: a - b - bin, one bit per clock, LSB first,
// through a single full-subtractor cell and a registered borrow.
module serial_sub_4bit #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_sub_4bit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             br;
    logic             br_next;
    logic             d_bit;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last;
    logic             busy_c;
    logic             done_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy_c = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                busy_c     = 1'b1;
                done_c     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Full-subtractor cell on the current LSBs of the operand shift registers.
    always_comb begin
        d_bit    = a_sh[0] ^ b_sh[0] ^ br;
        br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        res_next = {d_bit, res_sh};
    end

    // Only WIDTH-1 result bits need storing; the final bit goes straight into diff.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else if (accept) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
            br   <= bus.bin;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_next[WIDTH-1:1];
            br     <= br_next;
            cnt    <= cnt + 1'b1;
            if (last) begin
                diff_q <= res_next;
                bout_q <= br_next;
            end
        end
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_sub_4bit.sv
// Self-checking bench for serial_sub_4bit: cycle-level reference model driven
// by the same inputs, plus directed cases with hand-computed results.
module tb_serial_sub_4bit;
    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    serial_sub_4bit_if #(.WIDTH(WIDTH)) bus();

    serial_sub_4bit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_vec     = 0;
    int n_miscomp = 0;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miscomp++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_miscomp++;
        $display("[TB] FAIL %s: actual=timeout required=done", name);
    endtask

    // Reference model: phase counts edges since acceptance (0 = idle);
    // the result is plain (WIDTH+1)-bit subtraction.
    int               phase       = 0;
    logic [WIDTH:0]   pending     = '0;
    logic [WIDTH-1:0] exp_diff    = '0;
    logic             exp_bout    = 1'b0;
    bit               model_valid = 1'b0;
    int               exp_dones   = 0;
    int               dut_dones   = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            phase       = 0;
            exp_diff    = '0;
            exp_bout    = 1'b0;
            model_valid = 1'b1;
        end else if (phase == 0) begin
            if (bus.start === 1'b1) begin
                phase   = 1;
                pending = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, bus.bin};
            end
        end else begin
            phase++;
            if (phase == WIDTH + 1) begin
                {exp_bout, exp_diff} = pending;
                exp_dones++;
            end else if (phase == WIDTH + 2) begin
                phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check_output("busy", bus.busy, phase != 0);
            check_output("done", bus.done, phase == WIDTH + 1);
            check_output("diff", bus.diff, exp_diff);
            check_output("bout", bus.bout, exp_bout);
            if (bus.done === 1'b1) dut_dones++;
        end
    end

    task automatic apply_stimulus(input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v,
                                  input logic bin_v);
        bus.start = 1'b1;
        bus.a     = a_v;
        bus.b     = b_v;
        bus.bin   = bin_v;
    endtask

    // Issue one operation from idle and return its result; leaves the FSM idle.
    task automatic run_op(input logic [WIDTH-1:0] a_v, input logic [WIDTH-1:0] b_v,
                          input logic bin_v, output logic [WIDTH-1:0] d,
                          output logic bo, output int busy_cycles);
        bit got = 1'b0;
        d  = 'x;
        bo = 1'bx;
        apply_stimulus(a_v, b_v, bin_v);
        @(negedge clk);
        bus.start   = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            if (bus.busy === 1'b1) busy_cycles++;
            if (bus.done === 1'b1) begin
                got = 1'b1;
                d   = bus.diff;
                bo  = bus.bout;
            end else begin
                @(negedge clk);
            end
        end
        if (!got) fail_now("op_timeout");
        @(negedge clk);
    endtask

    logic [WIDTH-1:0] d;
    logic             bo;
    int               bc;
    int               ndone;
    int               lhs;
    int               rhs;
    logic [WIDTH:0]   r1;
    logic [WIDTH:0]   r2;

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        repeat (3) @(negedge clk);
        check_output("rst_busy", bus.busy, 1'b0);
        check_output("rst_done", bus.done, 1'b0);
        check_output("rst_diff", bus.diff, 4'h0);
        check_output("rst_bout", bus.bout, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed operations");
        run_op(4'd9, 4'd3, 1'b0, d, bo, bc);
        check_output("t1_diff", d, 4'h6);
        check_output("t1_bout", bo, 1'b0);
        check_output("t1_busy_cycles", bc, 5);
        check_output("t1_busy_after", bus.busy, 1'b0);
        check_output("t1_model", {exp_bout, exp_diff}, 5'h06);

        run_op(4'd3, 4'd9, 1'b0, d, bo, bc);
        check_output("t2_diff", d, 4'hA);
        check_output("t2_bout", bo, 1'b1);
        check_output("t2_model", {exp_bout, exp_diff}, 5'h1A);
        run_op(4'd0, 4'd0, 1'b1, d, bo, bc);
        check_output("t3_diff", d, 4'hF);
        check_output("t3_bout", bo, 1'b1);
        run_op(4'd15, 4'd15, 1'b1, d, bo, bc);
        check_output("t4_diff", d, 4'hF);
        check_output("t4_bout", bo, 1'b1);

        $display("[TB] exhaustive sweep");
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    run_op(4'(ia), 4'(ib), 1'(ic), d, bo, bc);
                    lhs = int'(d) + ib + ic;
                    rhs = ia + 16 * int'(bo);
                    check_output($sformatf("identity_%0d_%0d_%0d", ia, ib, ic), lhs, rhs);
                end
            end
        end

        $display("[TB] start held high with toggling operands");
        ndone = 0;
        r1    = '0;
        r2    = '0;
        apply_stimulus(4'd10, 4'd4, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k <= 7) check_output($sformatf("held_busy_%0d", k), bus.busy, k != 6);
            if (bus.done === 1'b1) begin
                if (ndone == 0) r1 = {bus.bout, bus.diff};
                else r2 = {bus.bout, bus.diff};
                ndone++;
            end
            if (k % 2 == 0) begin
                bus.a = 4'd13;
                bus.b = 4'd2;
            end else begin
                bus.a = 4'd1;
                bus.b = 4'd7;
            end
            if (k == 7) bus.start = 1'b0;
        end
        check_output("held_ndone", ndone, 2);
        check_output("held_r1", r1, 5'h06);
        check_output("held_r2", r2, 5'h0B);

        $display("[TB] reset during RUN");
        apply_stimulus(4'd12, 4'd5, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_output("abort_busy", bus.busy, 1'b0);
        check_output("abort_diff", bus.diff, 4'h0);
        check_output("abort_bout", bus.bout, 1'b0);
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        check_output("abort_no_done", ndone, 0);
        run_op(4'd12, 4'd5, 1'b0, d, bo, bc);
        check_output("after_abort_diff", d, 4'h7);
        check_output("after_abort_bout", bo, 1'b0);

        $display("[TB] reset and start on the same edge");
        rst_n = 1'b0;
        apply_stimulus(4'd3, 4'd1, 1'b0);
        @(negedge clk);
        check_output("rst_start_busy", bus.busy, 1'b0);
        bus.start = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        check_output("rst_start_busy2", bus.busy, 1'b0);
        check_output("rst_start_done", bus.done, 1'b0);

        repeat (2) @(negedge clk);
        check_output("done_count", dut_dones, exp_dones);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscomp);
        $finish;
    end
endmodule
